pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Parametrised hazard and forwarding controller for the 5-stage pipelined datapath (IF/ID/EX/MEM/WB).
- Generates EX-stage forwarding selects.
- Detects load-use hazards and inserts bubbles.
- Flushes the pipeline on a taken branch resolved in MEM.
- Freezes the pipeline while a multi-cycle data memory access completes.
- Keeps saturating stall and flush performance counters.
Sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers and drives their write/flush/hold controls and the PC write enable.

Parameters:
REG_ADDR_W, 5, register address width.
MEM_LATENCY, 1, cycles one data memory access occupies MEM (legal range 1..16).
STALL_CNT_W, 32, width of stall_cycles counter.
FLUSH_CNT_W, 16, width of flush_count counter.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
id_rs  in  REG_ADDR_W  IF/ID instruction rs field.
id_rt  in  REG_ADDR_W  IF/ID instruction rt field.
ex_rs  in  REG_ADDR_W  ID/EX rs.
ex_rt  in  REG_ADDR_W  ID/EX rt.
ex_mem_read  in  1  ID/EX instruction is a load.
mem_write_reg  in  REG_ADDR_W  EX/MEM destination register.
mem_reg_write  in  1  EX/MEM regWrite.
mem_access  in  1  EX/MEM instruction reads or writes data memory.
branch_taken  in  1  EX/MEM branch AND zero.
wb_write_reg  in  REG_ADDR_W  MEM/WB destination register.
wb_reg_write  in  1  MEM/WB regWrite.
forward_a  out  2  ALU input A select.
forward_b  out  2  ALU input B select.
pc_write  out  1  PC load enable.
if_id_write  out  1  IF/ID load enable.
id_ex_bubble  out  1  load zero controls into ID/EX.
if_id_flush  out  1  clear IF/ID.
id_ex_flush  out  1  clear ID/EX.
ex_mem_flush  out  1  clear EX/MEM.
pipe_freeze  out  1  hold ID/EX and EX/MEM contents.
mem_wb_bubble  out  1  load zero controls into MEM/WB.
stall_cycles  out  STALL_CNT_W  cycles with pc_write=0, saturating.
flush_count  out  FLUSH_CNT_W  taken-branch flush events, saturating.

Behaviour:
Reset
- While reset=1 (combinational override): pc_write=0, if_id_write=0, forward_a=forward_b=00, all flush/bubble/freeze outputs 0.
- On the clock edge with reset=1: state<=RUN, wait counter<=0, stall_cycles<=0, flush_count<=0.
- Reset during MEM_WAIT abandons the access; the next cycle is RUN.
- Reset cycles are not counted.

Forwarding (combinational, independent of state)
- forward_a = 10 if mem_reg_write && mem_write_reg!=0 && mem_write_reg==ex_rs.
- Else forward_a = 01 if wb_reg_write && wb_write_reg!=0 && wb_write_reg==ex_rs.
- Else forward_a = 00.
- forward_b is identical, using ex_rt.
- EX/MEM wins when both stages match. Register 0 is never forwarded.

FSM states: RUN, MEM_WAIT. Wait counter width is 4 bits.

Decision priority each cycle: freeze > branch flush > load-use > normal.

Freeze
- Condition: (state==RUN && mem_access && MEM_LATENCY>1) or (state==MEM_WAIT && cnt!=0).
- Outputs: pc_write=0, if_id_write=0, pipe_freeze=1, mem_wb_bubble=1. No other flush or bubble is asserted.
- From RUN: next state MEM_WAIT, cnt<=MEM_LATENCY-2.
- In MEM_WAIT with cnt!=0: cnt<=cnt-1.
- Result: exactly MEM_LATENCY-1 frozen cycles per access.

Release
- Condition: state==MEM_WAIT && cnt==0.
- Outputs are computed as in RUN, but mem_access is ignored.
- Next state is RUN.
- MEM_LATENCY=1: MEM_WAIT is never entered.

Branch flush
- Applies when not frozen and branch_taken=1.
- Outputs: if_id_flush=1, id_ex_flush=1, ex_mem_flush=1, pc_write=1, if_id_write=1, id_ex_bubble=0.
- flush_count increments.
- If branch_taken and mem_access are asserted together, the freeze is taken first; the flush is applied on the release cycle.

Load-use
- Condition: not frozen, no branch, ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || ex_rt==id_rt).
- Outputs: pc_write=0, if_id_write=0, id_ex_bubble=1 for one cycle.

Normal
- pc_write=1, if_id_write=1, all other control outputs 0.

Counters
- stall_cycles increments on every non-reset cycle with pc_write=0.
- Both counters hold at all-ones (no wrap).

Test Plan:
1. Forwarding: ex_rs=3, ex_rt=3, mem_write_reg=3, mem_reg_write=1, wb_write_reg=3, wb_reg_write=1 -> forward_a=forward_b=10. Drop mem_reg_write -> both 01. Set all register fields to 0 -> both 00.
2. Load-use: ex_mem_read=1, ex_rt=5, id_rt=5 -> one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1, stall_cycles 0->1. Repeat with ex_rt=0 -> no stall.
3. Branch flush: branch_taken=1 while a load-use condition is also present -> if_id_flush=id_ex_flush=ex_mem_flush=1, pc_write=1, id_ex_bubble=0, flush_count 0->1.
4. MEM_LATENCY=3: mem_access held high for 3 cycles -> cycles 1-2 pipe_freeze=1, mem_wb_bubble=1, pc_write=0; cycle 3 normal; stall_cycles=2. MEM_LATENCY=1 -> no freeze.
5. MEM_LATENCY=3 with mem_access=1 and branch_taken=1 together -> 2 frozen cycles, then the flush on cycle 3, flush_count=1. Reset asserted in the first MEM_WAIT cycle -> next cycle RUN, both counters 0.
6. Saturation: STALL_CNT_W=4, hold a load-use condition for 20 cycles -> stall_cycles stops at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and forwarding controller for a 5-stage IF/ID/EX/MEM/WB pipeline.
// Drives forwarding selects, stall/flush/freeze controls and saturating perf counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned STALL_CNT_W = 32,
    parameter int unsigned FLUSH_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [REG_ADDR_W-1:0]  id_rs,
    input  logic [REG_ADDR_W-1:0]  id_rt,
    input  logic [REG_ADDR_W-1:0]  ex_rs,
    input  logic [REG_ADDR_W-1:0]  ex_rt,
    input  logic                   ex_mem_read,
    input  logic [REG_ADDR_W-1:0]  mem_write_reg,
    input  logic                   mem_reg_write,
    input  logic                   mem_access,
    input  logic                   branch_taken,
    input  logic [REG_ADDR_W-1:0]  wb_write_reg,
    input  logic                   wb_reg_write,
    output logic [1:0]             forward_a,
    output logic [1:0]             forward_b,
    output logic                   pc_write,
    output logic                   if_id_write,
    output logic                   id_ex_bubble,
    output logic                   if_id_flush,
    output logic                   id_ex_flush,
    output logic                   ex_mem_flush,
    output logic                   pipe_freeze,
    output logic                   mem_wb_bubble,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic [FLUSH_CNT_W-1:0] flush_count
);

    localparam int unsigned WAIT_W = 4;
    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;
    localparam bit MULTI_CYCLE = (MEM_LATENCY > 1);
    localparam logic [WAIT_W-1:0] WAIT_INIT =
        MULTI_CYCLE ? WAIT_W'(MEM_LATENCY - 2) : '0;

    logic [0:0]             state_q, state_d;
    logic [WAIT_W-1:0]      cnt_q, cnt_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic [FLUSH_CNT_W-1:0] flush_q, flush_d;
    logic                   flush_evt;
    logic                   freeze_start;
    logic                   freeze_hold;
    logic                   load_use;

    // A new access only starts a freeze from RUN, so the release cycle ignores mem_access.
    assign freeze_start = (state_q == ST_RUN) && mem_access && MULTI_CYCLE;
    assign freeze_hold  = (state_q == ST_MEM_WAIT) && (cnt_q != '0);
    assign load_use     = ex_mem_read && (ex_rt != '0) &&
                          ((ex_rt == id_rs) || (ex_rt == id_rt));

    // EX/MEM result has priority over MEM/WB; register 0 is never forwarded.
    always_comb begin
        forward_a = 2'b00;
        forward_b = 2'b00;
        if (!reset) begin
            if (mem_reg_write && (mem_write_reg != '0) && (mem_write_reg == ex_rs)) begin
                forward_a = 2'b10;
            end else if (wb_reg_write && (wb_write_reg != '0) && (wb_write_reg == ex_rs)) begin
                forward_a = 2'b01;
            end
            if (mem_reg_write && (mem_write_reg != '0) && (mem_write_reg == ex_rt)) begin
                forward_b = 2'b10;
            end else if (wb_reg_write && (wb_write_reg != '0) && (wb_write_reg == ex_rt)) begin
                forward_b = 2'b01;
            end
        end
    end

    // Priority: freeze > branch flush > load-use > normal.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        id_ex_bubble  = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_flush  = 1'b0;
        pipe_freeze   = 1'b0;
        mem_wb_bubble = 1'b0;
        flush_evt     = 1'b0;
        if (reset) begin
            state_d = ST_RUN;
            cnt_d   = '0;
        end else if (freeze_start || freeze_hold) begin
            pipe_freeze   = 1'b1;
            mem_wb_bubble = 1'b1;
            if (freeze_start) begin
                state_d = ST_MEM_WAIT;
                cnt_d   = WAIT_INIT;
            end else begin
                cnt_d = cnt_q - WAIT_W'(1);
            end
        end else begin
            state_d = ST_RUN;
            if (branch_taken) begin
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
                pc_write     = 1'b1;
                if_id_write  = 1'b1;
                flush_evt    = 1'b1;
            end else if (load_use) begin
                id_ex_bubble = 1'b1;
            end else begin
                pc_write    = 1'b1;
                if_id_write = 1'b1;
            end
        end
    end

    // Saturating performance counters.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!pc_write && (stall_q != '1)) begin
            stall_d = stall_q + STALL_CNT_W'(1);
        end
        if (flush_evt && (flush_q != '1)) begin
            flush_d = flush_q + FLUSH_CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: instance A (MEM_LATENCY=1, 4-bit stall counter)
// and instance B (MEM_LATENCY=3) share stimulus; expectations are queued per cycle.
module tb_pipeline_hazard_ctrl;

    localparam logic [7:0] C_RST  = 8'b0000_0000;
    localparam logic [7:0] C_NORM = 8'b1100_0000;
    localparam logic [7:0] C_LU   = 8'b0010_0000;
    localparam logic [7:0] C_BR   = 8'b1101_1100;
    localparam logic [7:0] C_FRZ  = 8'b0000_0011;

    typedef struct {
        bit          sel;
        logic [59:0] v;
        string       name;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, mem_write_reg, wb_write_reg;
    logic       ex_mem_read, mem_reg_write, mem_access, branch_taken, wb_reg_write;

    logic [1:0]  a_fa, a_fb, b_fa, b_fb;
    logic        a_pcw, a_ifw, a_bub, a_iff, a_ief, a_emf, a_frz, a_mwb;
    logic        b_pcw, b_ifw, b_bub, b_iff, b_ief, b_emf, b_frz, b_mwb;
    logic [3:0]  a_stall;
    logic [31:0] b_stall;
    logic [15:0] a_flush, b_flush;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .MEM_LATENCY(1), .STALL_CNT_W(4), .FLUSH_CNT_W(16)) dut_a (
        .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_mem_read(ex_mem_read), .mem_write_reg(mem_write_reg), .mem_reg_write(mem_reg_write),
        .mem_access(mem_access), .branch_taken(branch_taken), .wb_write_reg(wb_write_reg),
        .wb_reg_write(wb_reg_write), .forward_a(a_fa), .forward_b(a_fb), .pc_write(a_pcw),
        .if_id_write(a_ifw), .id_ex_bubble(a_bub), .if_id_flush(a_iff), .id_ex_flush(a_ief),
        .ex_mem_flush(a_emf), .pipe_freeze(a_frz), .mem_wb_bubble(a_mwb),
        .stall_cycles(a_stall), .flush_count(a_flush)
    );

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .MEM_LATENCY(3), .STALL_CNT_W(32), .FLUSH_CNT_W(16)) dut_b (
        .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_mem_read(ex_mem_read), .mem_write_reg(mem_write_reg), .mem_reg_write(mem_reg_write),
        .mem_access(mem_access), .branch_taken(branch_taken), .wb_write_reg(wb_write_reg),
        .wb_reg_write(wb_reg_write), .forward_a(b_fa), .forward_b(b_fb), .pc_write(b_pcw),
        .if_id_write(b_ifw), .id_ex_bubble(b_bub), .if_id_flush(b_iff), .id_ex_flush(b_ief),
        .ex_mem_flush(b_emf), .pipe_freeze(b_frz), .mem_wb_bubble(b_mwb),
        .stall_cycles(b_stall), .flush_count(b_flush)
    );

    function automatic logic [59:0] obs(input bit sel);
        if (sel)
            return {b_fa, b_fb, b_pcw, b_ifw, b_bub, b_iff, b_ief, b_emf, b_frz, b_mwb, b_stall, b_flush};
        return {a_fa, a_fb, a_pcw, a_ifw, a_bub, a_iff, a_ief, a_emf, a_frz, a_mwb, 32'(a_stall), a_flush};
    endfunction

    task automatic push(input bit sel, input logic [1:0] fa, input logic [1:0] fb,
                        input logic [7:0] c, input int unsigned st, input int unsigned fl,
                        input string nm);
        exp_t e;
        e.sel  = sel;
        e.v    = {fa, fb, c, st, 16'(fl)};
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic push_both(input logic [1:0] fa, input logic [1:0] fb, input logic [7:0] c,
                             input int unsigned st, input int unsigned fl, input string nm);
        push(1'b0, fa, fb, c, st, fl, nm);
        push(1'b1, fa, fb, c, st, fl, nm);
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0;
        mem_write_reg = '0; wb_write_reg = '0;
        ex_mem_read = 1'b0; mem_reg_write = 1'b0; mem_access = 1'b0;
        branch_taken = 1'b0; wb_reg_write = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [59:0] got;
        clear_inputs();
        reset = 1'b1;
        ex_rs = 5'd3; mem_write_reg = 5'd3; mem_reg_write = 1'b1;
        ex_mem_read = 1'b1; ex_rt = 5'd4; id_rt = 5'd4; mem_access = 1'b1; branch_taken = 1'b1;
        @(posedge clock); #1;
        for (int c = 0; c < 2; c++) begin
            push_both(2'b00, 2'b00, C_RST, 0, 0, $sformatf("reset_c%0d", c));
            @(negedge clock);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                got = obs(e.sel);
                n_cmp++;
                if (got !== e.v) begin
                    n_err++;
                    $display("FAIL %s dut%0d got=%h want=%h", e.name, e.sel, got, e.v);
                end
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_forwarding();
        exp_t e;
        logic [59:0] got;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            case (c)
                0: begin
                    ex_rs = 5'd3; ex_rt = 5'd3; mem_write_reg = 5'd3; mem_reg_write = 1'b1;
                    wb_write_reg = 5'd3; wb_reg_write = 1'b1;
                    push_both(2'b10, 2'b10, C_NORM, 0, 0, "fwd_mem_wins");
                end
                1: begin
                    mem_reg_write = 1'b0;
                    push_both(2'b01, 2'b01, C_NORM, 0, 0, "fwd_wb");
                end
                2: begin
                    ex_rs = '0; ex_rt = '0; mem_write_reg = '0; wb_write_reg = '0;
                    mem_reg_write = 1'b1;
                    push_both(2'b00, 2'b00, C_NORM, 0, 0, "fwd_reg0");
                end
                default: begin
                    ex_rs = 5'd4; ex_rt = 5'd7; mem_write_reg = 5'd7; wb_write_reg = 5'd4;
                    push_both(2'b01, 2'b10, C_NORM, 0, 0, "fwd_mixed");
                end
            endcase
            @(negedge clock);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                got = obs(e.sel);
                n_cmp++;
                if (got !== e.v) begin
                    n_err++;
                    $display("FAIL %s dut%0d got=%h want=%h", e.name, e.sel, got, e.v);
                end
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_load_use();
        exp_t e;
        logic [59:0] got;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            clear_inputs();
            case (c)
                0: begin
                    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rt = 5'd5;
                    push_both(2'b00, 2'b00, C_LU, 0, 0, "lu_rt_stall");
                end
                1: push_both(2'b00, 2'b00, C_NORM, 1, 0, "lu_after");
                2: begin
                    ex_mem_read = 1'b1;
                    push_both(2'b00, 2'b00, C_NORM, 1, 0, "lu_reg0");
                end
                3: begin
                    ex_mem_read = 1'b1; ex_rt = 5'd6; id_rs = 5'd6;
                    push_both(2'b00, 2'b00, C_LU, 1, 0, "lu_rs_stall");
                end
                default: push_both(2'b00, 2'b00, C_NORM, 2, 0, "lu_end");
            endcase
            @(negedge clock);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                got = obs(e.sel);
                n_cmp++;
                if (got !== e.v) begin
                    n_err++;
                    $display("FAIL %s dut%0d got=%h want=%h", e.name, e.sel, got, e.v);
                end
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_branch();
        exp_t e;
        logic [59:0] got;
        do_reset();
        for (int c = 0; c < 2; c++) begin
            clear_inputs();
            if (c == 0) begin
                branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd5; id_rt = 5'd5;
                push_both(2'b00, 2'b00, C_BR, 0, 0, "br_over_lu");
            end else begin
                push_both(2'b00, 2'b00, C_NORM, 0, 1, "br_count");
            end
            @(negedge clock);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                got = obs(e.sel);
                n_cmp++;
                if (got !== e.v) begin
                    n_err++;
                    $display("FAIL %s dut%0d got=%h want=%h", e.name, e.sel, got, e.v);
                end
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_mem_freeze();
        exp_t e;
        logic [59:0] got;
        logic [7:0] bc [4] = '{C_FRZ, C_FRZ, C_NORM, C_NORM};
        int unsigned bs [4] = '{0, 1, 2, 2};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            mem_access = (c < 3);
            push(1'b0, 2'b00, 2'b00, C_NORM, 0, 0, $sformatf("lat1_c%0d", c));
            push(1'b1, 2'b00, 2'b00, bc[c], bs[c], 0, $sformatf("lat3_c%0d", c));
            @(negedge clock);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                got = obs(e.sel);
                n_cmp++;
                if (got !== e.v) begin
                    n_err++;
                    $display("FAIL %s dut%0d got=%h want=%h", e.name, e.sel, got, e.v);
                end
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_freeze_branch();
        exp_t e;
        logic [59:0] got;
        logic [7:0] bc [4] = '{C_FRZ, C_FRZ, C_BR, C_NORM};
        int unsigned bs [4] = '{0, 1, 2, 2};
        int unsigned bf [4] = '{0, 0, 0, 1};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            mem_access   = (c < 3);
            branch_taken = (c < 3);
            push(1'b0, 2'b00, 2'b00, (c < 3) ? C_BR : C_NORM, 0, c, $sformatf("frzbr_a_c%0d", c));
            push(1'b1, 2'b00, 2'b00, bc[c], bs[c], bf[c], $sformatf("frzbr_b_c%0d", c));
            @(negedge clock);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                got = obs(e.sel);
                n_cmp++;
                if (got !== e.v) begin
                    n_err++;
                    $display("FAIL %s dut%0d got=%h want=%h", e.name, e.sel, got, e.v);
                end
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset_in_wait();
        exp_t e;
        logic [59:0] got;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            clear_inputs();
            reset = 1'b0;
            case (c)
                0: begin
                    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rt = 5'd5;
                    push_both(2'b00, 2'b00, C_LU, 0, 0, "rw_lu");
                end
                1: begin
                    mem_access = 1'b1;
                    push(1'b0, 2'b00, 2'b00, C_NORM, 1, 0, "rw_enter_a");
                    push(1'b1, 2'b00, 2'b00, C_FRZ, 1, 0, "rw_enter_b");
                end
                2: begin
                    mem_access = 1'b1; reset = 1'b1;
                    push(1'b0, 2'b00, 2'b00, C_RST, 1, 0, "rw_reset_a");
                    push(1'b1, 2'b00, 2'b00, C_RST, 2, 0, "rw_reset_b");
                end
                3: begin
                    mem_access = 1'b1;
                    push(1'b0, 2'b00, 2'b00, C_NORM, 0, 0, "rw_run_a");
                    push(1'b1, 2'b00, 2'b00, C_FRZ, 0, 0, "rw_run_b");
                end
                4: begin
                    push(1'b0, 2'b00, 2'b00, C_NORM, 0, 0, "rw_hold_a");
                    push(1'b1, 2'b00, 2'b00, C_FRZ, 1, 0, "rw_hold_b");
                end
                default: begin
                    push(1'b0, 2'b00, 2'b00, C_NORM, 0, 0, "rw_rel_a");
                    push(1'b1, 2'b00, 2'b00, C_NORM, 2, 0, "rw_rel_b");
                end
            endcase
            @(negedge clock);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                got = obs(e.sel);
                n_cmp++;
                if (got !== e.v) begin
                    n_err++;
                    $display("FAIL %s dut%0d got=%h want=%h", e.name, e.sel, got, e.v);
                end
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        logic [59:0] got;
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            clear_inputs();
            if (c < 20) begin
                ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
                push(1'b0, 2'b00, 2'b00, C_LU, (c > 15) ? 15 : c, 0, $sformatf("sat_a_c%0d", c));
                push(1'b1, 2'b00, 2'b00, C_LU, c, 0, $sformatf("sat_b_c%0d", c));
            end else begin
                push(1'b0, 2'b00, 2'b00, C_NORM, 15, 0, "sat_a_hold");
                push(1'b1, 2'b00, 2'b00, C_NORM, 20, 0, "sat_b_end");
            end
            @(negedge clock);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                got = obs(e.sel);
                n_cmp++;
                if (got !== e.v) begin
                    n_err++;
                    $display("FAIL %s dut%0d got=%h want=%h", e.name, e.sel, got, e.v);
                end
            end
            @(posedge clock); #1;
        end
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_mem_freeze();
        test_freeze_branch();
        test_reset_in_wait();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
